ahb_lite_arbiter: RTL and testbench

//  Shares one AHB-Lite bus between NUM_M masters, in front of the address decoder and slave response mux.
//  - One owner at a time. Handover only at idle address phases. Round-robin among waiting masters.
//  - Non-owners that request are held off with HREADY_M=0.
//  - Bus returns (HRDATA/HRESP/HREADY) are routed back to the owner.

---
 rtl/ahb_lite_arb_pkg.sv | 24 ++
 rtl/ahb_lite_rr_pick.sv | 36 +++
 rtl/ahb_lite_arbiter.sv | 117 +++++++++++
 tb/tb_ahb_lite_arbiter.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_lite_arb_pkg.sv
// Shared AHB-Lite encodings and the master index type for the bus arbiter.
// Combinational helpers only; no latency and no backpressure of their own.
`ifndef BUS_WIDTH
`define BUS_WIDTH 32
`endif

package ahb_lite_arb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef logic [1:0] master_idx_t;

    // BUSY keeps a burst alive but is not a new address, so it never asks for the bus.
    function automatic logic is_request(input logic [1:0] trans);
        return (trans == HTRANS_NONSEQ) || (trans == HTRANS_SEQ);
    endfunction

endpackage

// File: rtl/ahb_lite_rr_pick.sv
// Round-robin picker: first requester after the last owner, wrapping modulo NUM_M.
// Purely combinational; the last owner itself is never a candidate.
module ahb_lite_rr_pick
    import ahb_lite_arb_pkg::*;
#(
    parameter int NUM_M = 2
) (
    input  logic [NUM_M-1:0] req,
    input  master_idx_t      last,
    output master_idx_t      winner,
    output logic             valid
);

    logic [3:0] req4;
    logic [2:0] cand;

    assign req4 = 4'(req);

    // Scan from the farthest offset down so the nearest requester is written last and wins.
    always_comb begin
        winner = last;
        valid  = 1'b0;
        cand   = 3'd0;
        for (int i = NUM_M - 1; i >= 1; i--) begin
            cand = {1'b0, last} + 3'(i);
            if (cand >= 3'(NUM_M)) begin
                cand = cand - 3'(NUM_M);
            end
            if (req4[cand[1:0]]) begin
                winner = cand[1:0];
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ahb_lite_arbiter.sv
// AHB-Lite multi-master arbiter: grant register, owner muxes, HREADY_M hold-off of waiting masters.
// Handover only on an idle, ready owner address phase; AHB_ARB_LOCK_EN makes HMASTLOCK block handover.
module ahb_lite_arbiter
    import ahb_lite_arb_pkg::*;
#(
    parameter int NUM_M  = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = `BUS_WIDTH
) (
    input  logic                     HCLK,
    input  logic                     HRESETn,
    input  logic [NUM_M*ADDR_W-1:0]  HADDR_M,
    input  logic [NUM_M*2-1:0]       HTRANS_M,
    input  logic [NUM_M-1:0]         HWRITE_M,
    input  logic [NUM_M*3-1:0]       HSIZE_M,
    input  logic [NUM_M*3-1:0]       HBURST_M,
    input  logic [NUM_M*4-1:0]       HPROT_M,
    input  logic [NUM_M*DATA_W-1:0]  HWDATA_M,
    input  logic [NUM_M-1:0]         HMASTLOCK_M,
    output logic [NUM_M-1:0]         HREADY_M,
    output logic [NUM_M-1:0]         HRESP_M,
    output logic [DATA_W-1:0]        HRDATA_M,
    output logic [ADDR_W-1:0]        HADDR,
    output logic [1:0]               HTRANS,
    output logic                     HWRITE,
    output logic [2:0]               HSIZE,
    output logic [2:0]               HBURST,
    output logic [3:0]               HPROT,
    output logic [DATA_W-1:0]        HWDATA,
    output logic                     HMASTLOCK,
    input  logic                     HREADY,
    input  logic                     HRESP,
    input  logic [DATA_W-1:0]        HRDATA,
    output logic [1:0]               HMASTER
);

    master_idx_t      grant;
    master_idx_t      pick_idx;
    logic             pick_vld;
    logic             handover;
    logic             lock_hold;
    logic             owner_lock;
    logic [NUM_M-1:0] req;

    ahb_lite_rr_pick #(
        .NUM_M (NUM_M)
    ) u_pick (
        .req    (req),
        .last   (grant),
        .winner (pick_idx),
        .valid  (pick_vld)
    );

    // HWDATA follows the grant too: the data phase right after a handover is always IDLE.
    always_comb begin
        HADDR      = '0;
        HTRANS     = HTRANS_IDLE;
        HWRITE     = 1'b0;
        HSIZE      = '0;
        HBURST     = '0;
        HPROT      = '0;
        HWDATA     = '0;
        owner_lock = 1'b0;
        for (int m = 0; m < NUM_M; m++) begin
            if (grant == master_idx_t'(m)) begin
                HADDR      = HADDR_M[m*ADDR_W +: ADDR_W];
                HTRANS     = HTRANS_M[m*2 +: 2];
                HWRITE     = HWRITE_M[m];
                HSIZE      = HSIZE_M[m*3 +: 3];
                HBURST     = HBURST_M[m*3 +: 3];
                HPROT      = HPROT_M[m*4 +: 4];
                HWDATA     = HWDATA_M[m*DATA_W +: DATA_W];
                owner_lock = HMASTLOCK_M[m];
            end
        end
    end

    always_comb begin
        req      = '0;
        HREADY_M = '1;
        HRESP_M  = '0;
        for (int m = 0; m < NUM_M; m++) begin
            req[m] = is_request(HTRANS_M[m*2 +: 2]);
            if (grant == master_idx_t'(m)) begin
                HREADY_M[m] = HREADY;
                HRESP_M[m]  = HRESP;
            end else begin
                HREADY_M[m] = !req[m];
                HRESP_M[m]  = HRESP_OKAY;
            end
        end
    end

`ifdef AHB_ARB_LOCK_EN
    assign lock_hold = owner_lock;
    assign HMASTLOCK = owner_lock;
`else
    logic unused_lock;
    assign lock_hold   = 1'b0;
    assign HMASTLOCK   = 1'b0;
    assign unused_lock = owner_lock;
`endif

    assign handover = HREADY && (HTRANS == HTRANS_IDLE) && !lock_hold && pick_vld;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            grant <= '0;
        end else if (handover) begin
            grant <= pick_idx;
        end
    end

    assign HMASTER  = grant;
    assign HRDATA_M = HRDATA;

endmodule

// File: tb/tb_ahb_lite_arbiter.sv
// Scoreboard bench for ahb_lite_arbiter with three masters.
// Each row drives one address phase and queues the bus/response state it must produce.
module tb_ahb_lite_arbiter;

    localparam int NM = 3;
    localparam int VW = 118;
    localparam logic [1:0] TI = 2'b00;
    localparam logic [1:0] TN = 2'b10;
    localparam logic [1:0] TS = 2'b11;

    typedef struct {
        string       name;
        logic [1:0]  t0;
        logic [31:0] a0;
        logic [1:0]  t1;
        logic [31:0] a1;
        logic [1:0]  t2;
        logic [31:0] a2;
        logic        lk0;
        logic        rdy;
        logic        resp;
        logic [1:0]  em;
        logic [1:0]  et;
        logic [31:0] ea;
        logic [2:0]  erdy;
        logic [2:0]  eresp;
    } row_t;

    typedef struct {
        string         name;
        logic [VW-1:0] v;
    } exp_t;

    logic              HCLK = 1'b0;
    logic              HRESETn;
    logic [NM*32-1:0]  HADDR_M;
    logic [NM*2-1:0]   HTRANS_M;
    logic [NM-1:0]     HWRITE_M;
    logic [NM*3-1:0]   HSIZE_M;
    logic [NM*3-1:0]   HBURST_M;
    logic [NM*4-1:0]   HPROT_M;
    logic [NM*32-1:0]  HWDATA_M;
    logic [NM-1:0]     HMASTLOCK_M;
    logic [NM-1:0]     HREADY_M;
    logic [NM-1:0]     HRESP_M;
    logic [31:0]       HRDATA_M;
    logic [31:0]       HADDR;
    logic [1:0]        HTRANS;
    logic              HWRITE;
    logic [2:0]        HSIZE;
    logic [2:0]        HBURST;
    logic [3:0]        HPROT;
    logic [31:0]       HWDATA;
    logic              HMASTLOCK;
    logic              HREADY;
    logic              HRESP;
    logic [31:0]       HRDATA;
    logic [1:0]        HMASTER;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 HCLK = ~HCLK;

    ahb_lite_arbiter #(
        .NUM_M  (NM),
        .ADDR_W (32),
        .DATA_W (32)
    ) dut (
        .HCLK        (HCLK),
        .HRESETn     (HRESETn),
        .HADDR_M     (HADDR_M),
        .HTRANS_M    (HTRANS_M),
        .HWRITE_M    (HWRITE_M),
        .HSIZE_M     (HSIZE_M),
        .HBURST_M    (HBURST_M),
        .HPROT_M     (HPROT_M),
        .HWDATA_M    (HWDATA_M),
        .HMASTLOCK_M (HMASTLOCK_M),
        .HREADY_M    (HREADY_M),
        .HRESP_M     (HRESP_M),
        .HRDATA_M    (HRDATA_M),
        .HADDR       (HADDR),
        .HTRANS      (HTRANS),
        .HWRITE      (HWRITE),
        .HSIZE       (HSIZE),
        .HBURST      (HBURST),
        .HPROT       (HPROT),
        .HWDATA      (HWDATA),
        .HMASTLOCK   (HMASTLOCK),
        .HREADY      (HREADY),
        .HRESP       (HRESP),
        .HRDATA      (HRDATA),
        .HMASTER     (HMASTER)
    );

    // Static per-master attributes, so every owner has a recognisable signature on the bus.
    function automatic logic [42:0] exp_side(input logic [1:0] m);
        case (m)
            2'd0:    return {1'b1, 3'd0, 3'b011, 4'h1, 32'hD000_0000};
            2'd1:    return {1'b0, 3'd1, 3'b000, 4'h2, 32'hD000_0001};
            2'd2:    return {1'b1, 3'd2, 3'b001, 4'h4, 32'hD000_0002};
            default: return 43'd0;
        endcase
    endfunction

    function automatic logic [VW-1:0] observed();
        return {HMASTER, HTRANS, HADDR, HREADY_M, HRESP_M, HMASTLOCK, HRDATA_M,
                HWRITE, HSIZE, HBURST, HPROT, HWDATA};
    endfunction

    task automatic apply(input row_t r);
        logic elock;
        @(posedge HCLK);
        #1;
        HTRANS_M    = {r.t2, r.t1, r.t0};
        HADDR_M     = {r.a2, r.a1, r.a0};
        HMASTLOCK_M = {2'b00, r.lk0};
        HREADY      = r.rdy;
        HRESP       = r.resp;
        HRDATA      = $urandom;
`ifdef AHB_ARB_LOCK_EN
        elock = (r.em == 2'd0) && r.lk0;
`else
        elock = 1'b0;
`endif
        sb.push_back('{r.name, {r.em, r.et, r.ea, r.erdy, r.eresp, elock, HRDATA, exp_side(r.em)}});
    endtask

    task automatic test_reset();
        row_t rows[$];
        exp_t e;
        rows.push_back('{"rst_m1_req", TI, 32'h0,   TN, 32'hA0, TI, 32'h0, 1'b0, 1'b1, 1'b0, 2'd0, TI, 32'h0,   3'b101, 3'b000});
        rows.push_back('{"rst_hold",   TN, 32'hB0,  TN, 32'hA0, TI, 32'h0, 1'b0, 1'b1, 1'b0, 2'd0, TN, 32'hB0,  3'b101, 3'b000});
        foreach (rows[i]) begin
            apply(rows[i]);
            @(negedge HCLK);
            e = sb.pop_front();
            n_checks++;
            if (observed() !== e.v) begin
                n_fail++;
                $display("FAIL %s: observed %h required %h", e.name, observed(), e.v);
            end
        end
        HTRANS_M = '0;
        HADDR_M  = '0;
        HRESETn  = 1'b1;
    endtask

    task automatic test_park();
        row_t rows[$];
        exp_t e;
        rows.push_back('{"park_m0_read", TN, 32'h100, TI, 32'h0, TI, 32'h0, 1'b0, 1'b1, 1'b0, 2'd0, TN, 32'h100, 3'b111, 3'b000});
        rows.push_back('{"park_m0_idle", TI, 32'h0,   TI, 32'h0, TI, 32'h0, 1'b0, 1'b1, 1'b0, 2'd0, TI, 32'h0,   3'b111, 3'b000});
        foreach (rows[i]) begin
            apply(rows[i]);
            @(negedge HCLK);
            e = sb.pop_front();
            n_checks++;
            if (observed() !== e.v) begin
                n_fail++;
                $display("FAIL %s: observed %h required %h", e.name, observed(), e.v);
            end
        end
    endtask

    task automatic test_handover();
        row_t rows[$];
        exp_t e;
        rows.push_back('{"ho_m1_wait",  TI, 32'h0, TN, 32'h200, TI, 32'h0, 1'b0, 1'b1, 1'b0, 2'd0, TI, 32'h0,   3'b101, 3'b000});
        rows.push_back('{"ho_m1_owner", TI, 32'h0, TN, 32'h200, TI, 32'h0, 1'b0, 1'b1, 1'b0, 2'd1, TN, 32'h200, 3'b111, 3'b000});
        rows.push_back('{"ho_m1_park",  TI, 32'h0, TI, 32'h0,   TI, 32'h0, 1'b0, 1'b1, 1'b0, 2'd1, TI, 32'h0,   3'b111, 3'b000});
        foreach (rows[i]) begin
            apply(rows[i]);
            @(negedge HCLK);
            e = sb.pop_front();
            n_checks++;
            if (observed() !== e.v) begin
                n_fail++;
                $display("FAIL %s: observed %h required %h", e.name, observed(), e.v);
            end
        end
    endtask

    task automatic test_burst();
        row_t rows[$];
        exp_t e;
        rows.push_back('{"bu_m0_wait",  TN, 32'h300, TI, 32'h0,   TI, 32'h0, 1'b0, 1'b1, 1'b0, 2'd1, TI, 32'h0,   3'b110, 3'b000});
        rows.push_back('{"bu_beat1",    TN, 32'h300, TI, 32'h0,   TI, 32'h0, 1'b0, 1'b1, 1'b0, 2'd0, TN, 32'h300, 3'b111, 3'b000});
        rows.push_back('{"bu_beat2",    TS, 32'h304, TN, 32'h400, TI, 32'h0, 1'b0, 1'b1, 1'b0, 2'd0, TS, 32'h304, 3'b101, 3'b000});
        rows.push_back('{"bu_beat3",    TS, 32'h308, TN, 32'h400, TI, 32'h0, 1'b0, 1'b1, 1'b0, 2'd0, TS, 32'h308, 3'b101, 3'b000});
        rows.push_back('{"bu_beat4",    TS, 32'h30C, TN, 32'h400, TI, 32'h0, 1'b0, 1'b1, 1'b0, 2'd0, TS, 32'h30C, 3'b101, 3'b000});
        rows.push_back('{"bu_m0_idle",  TI, 32'h0,   TN, 32'h400, TI, 32'h0, 1'b0, 1'b1, 1'b0, 2'd0, TI, 32'h0,   3'b101, 3'b000});
        rows.push_back('{"bu_m1_owner", TI, 32'h0,   TN, 32'h400, TI, 32'h0, 1'b0, 1'b1, 1'b0, 2'd1, TN, 32'h400, 3'b111, 3'b000});
        rows.push_back('{"bu_m1_park",  TI, 32'h0,   TI, 32'h0,   TI, 32'h0, 1'b0, 1'b1, 1'b0, 2'd1, TI, 32'h0,   3'b111, 3'b000});
        foreach (rows[i]) begin
            apply(rows[i]);
            @(negedge HCLK);
            e = sb.pop_front();
            n_checks++;
            if (observed() !== e.v) begin
                n_fail++;
                $display("FAIL %s: observed %h required %h", e.name, observed(), e.v);
            end
        end
    endtask

    task automatic test_rr_wrap();
        row_t rows[$];
        exp_t e;
        rows.push_back('{"rr_both_req", TN, 32'h500, TI, 32'h0, TN, 32'h600, 1'b0, 1'b1, 1'b0, 2'd1, TI, 32'h0,   3'b010, 3'b000});
        rows.push_back('{"rr_m2_first", TN, 32'h500, TI, 32'h0, TN, 32'h600, 1'b0, 1'b1, 1'b0, 2'd2, TN, 32'h600, 3'b110, 3'b000});
        rows.push_back('{"rr_m2_idle",  TN, 32'h500, TI, 32'h0, TI, 32'h0,   1'b0, 1'b1, 1'b0, 2'd2, TI, 32'h0,   3'b110, 3'b000});
        rows.push_back('{"rr_wrap_m0",  TN, 32'h500, TI, 32'h0, TI, 32'h0,   1'b0, 1'b1, 1'b0, 2'd0, TN, 32'h500, 3'b111, 3'b000});
        rows.push_back('{"rr_m0_park",  TI, 32'h0,   TI, 32'h0, TI, 32'h0,   1'b0, 1'b1, 1'b0, 2'd0, TI, 32'h0,   3'b111, 3'b000});
        foreach (rows[i]) begin
            apply(rows[i]);
            @(negedge HCLK);
            e = sb.pop_front();
            n_checks++;
            if (observed() !== e.v) begin
                n_fail++;
                $display("FAIL %s: observed %h required %h", e.name, observed(), e.v);
            end
        end
    endtask

    task automatic test_wait_error();
        row_t rows[$];
        exp_t e;
        rows.push_back('{"we_m0_read",  TN, 32'h700, TI, 32'h0,   TI, 32'h0, 1'b0, 1'b1, 1'b0, 2'd0, TN, 32'h700, 3'b111, 3'b000});
        rows.push_back('{"we_wait1",    TI, 32'h0,   TN, 32'h800, TI, 32'h0, 1'b0, 1'b0, 1'b0, 2'd0, TI, 32'h0,   3'b100, 3'b000});
        rows.push_back('{"we_wait2",    TI, 32'h0,   TN, 32'h800, TI, 32'h0, 1'b0, 1'b0, 1'b0, 2'd0, TI, 32'h0,   3'b100, 3'b000});
        rows.push_back('{"we_err1",     TI, 32'h0,   TN, 32'h800, TI, 32'h0, 1'b0, 1'b0, 1'b1, 2'd0, TI, 32'h0,   3'b100, 3'b001});
        rows.push_back('{"we_err2",     TI, 32'h0,   TN, 32'h800, TI, 32'h0, 1'b0, 1'b1, 1'b1, 2'd0, TI, 32'h0,   3'b101, 3'b001});
        rows.push_back('{"we_m1_owner", TI, 32'h0,   TN, 32'h800, TI, 32'h0, 1'b0, 1'b1, 1'b0, 2'd1, TN, 32'h800, 3'b111, 3'b000});
        rows.push_back('{"we_m1_park",  TI, 32'h0,   TI, 32'h0,   TI, 32'h0, 1'b0, 1'b1, 1'b0, 2'd1, TI, 32'h0,   3'b111, 3'b000});
        foreach (rows[i]) begin
            apply(rows[i]);
            @(negedge HCLK);
            e = sb.pop_front();
            n_checks++;
            if (observed() !== e.v) begin
                n_fail++;
                $display("FAIL %s: observed %h required %h", e.name, observed(), e.v);
            end
        end
    endtask

    task automatic test_lock();
        row_t rows[$];
        exp_t e;
        rows.push_back('{"lk_m0_wait",  TN, 32'h900, TI, 32'h0,   TI, 32'h0, 1'b1, 1'b1, 1'b0, 2'd1, TI, 32'h0,   3'b110, 3'b000});
        rows.push_back('{"lk_m0_owner", TN, 32'h900, TI, 32'h0,   TI, 32'h0, 1'b1, 1'b1, 1'b0, 2'd0, TN, 32'h900, 3'b111, 3'b000});
        rows.push_back('{"lk_m0_idle",  TI, 32'h0,   TN, 32'hA00, TI, 32'h0, 1'b1, 1'b1, 1'b0, 2'd0, TI, 32'h0,   3'b101, 3'b000});
`ifdef AHB_ARB_LOCK_EN
        rows.push_back('{"lk_held",     TI, 32'h0,   TN, 32'hA00, TI, 32'h0, 1'b1, 1'b1, 1'b0, 2'd0, TI, 32'h0,   3'b101, 3'b000});
        rows.push_back('{"lk_drop",     TI, 32'h0,   TN, 32'hA00, TI, 32'h0, 1'b0, 1'b1, 1'b0, 2'd0, TI, 32'h0,   3'b101, 3'b000});
        rows.push_back('{"lk_m1_owner", TI, 32'h0,   TN, 32'hA00, TI, 32'h0, 1'b0, 1'b1, 1'b0, 2'd1, TN, 32'hA00, 3'b111, 3'b000});
`else
        rows.push_back('{"nolk_m1",     TI, 32'h0,   TN, 32'hA00, TI, 32'h0, 1'b1, 1'b1, 1'b0, 2'd1, TN, 32'hA00, 3'b111, 3'b000});
        rows.push_back('{"nolk_m1_b",   TI, 32'h0,   TN, 32'hA00, TI, 32'h0, 1'b0, 1'b1, 1'b0, 2'd1, TN, 32'hA00, 3'b111, 3'b000});
        rows.push_back('{"nolk_m1_c",   TI, 32'h0,   TN, 32'hA00, TI, 32'h0, 1'b0, 1'b1, 1'b0, 2'd1, TN, 32'hA00, 3'b111, 3'b000});
`endif
        foreach (rows[i]) begin
            apply(rows[i]);
            @(negedge HCLK);
            e = sb.pop_front();
            n_checks++;
            if (observed() !== e.v) begin
                n_fail++;
                $display("FAIL %s: observed %h required %h", e.name, observed(), e.v);
            end
        end
    endtask

    // Reset lands between clock edges while M1 owns the bus and is mid-transfer.
    task automatic test_async_reset();
        row_t rows[$];
        exp_t e;
        @(posedge HCLK);
        #1;
        HTRANS_M    = {TI, TN, TI};
        HADDR_M     = {32'h0, 32'hB00, 32'h0};
        HMASTLOCK_M = '0;
        HREADY      = 1'b1;
        HRESP       = 1'b0;
        HRDATA      = $urandom;
        sb.push_back('{"ar_before", {2'd1, TN, 32'hB00, 3'b111, 3'b000, 1'b0, HRDATA, exp_side(2'd1)}});
        #1;
        e = sb.pop_front();
        n_checks++;
        if (observed() !== e.v) begin
            n_fail++;
            $display("FAIL %s: observed %h required %h", e.name, observed(), e.v);
        end
        #1;
        HRESETn = 1'b0;
        sb.push_back('{"ar_after", {2'd0, TI, 32'h0, 3'b101, 3'b000, 1'b0, HRDATA, exp_side(2'd0)}});
        #1;
        e = sb.pop_front();
        n_checks++;
        if (observed() !== e.v) begin
            n_fail++;
            $display("FAIL %s: observed %h required %h", e.name, observed(), e.v);
        end
        @(negedge HCLK);
        HTRANS_M = '0;
        HADDR_M  = '0;
        HRESETn  = 1'b1;
        rows.push_back('{"ar_parked", TI, 32'h0, TI, 32'h0, TI, 32'h0, 1'b0, 1'b1, 1'b0, 2'd0, TI, 32'h0, 3'b111, 3'b000});
        foreach (rows[i]) begin
            apply(rows[i]);
            @(negedge HCLK);
            e = sb.pop_front();
            n_checks++;
            if (observed() !== e.v) begin
                n_fail++;
                $display("FAIL %s: observed %h required %h", e.name, observed(), e.v);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        HRESETn     = 1'b0;
        HADDR_M     = '0;
        HTRANS_M    = '0;
        HMASTLOCK_M = '0;
        HWRITE_M    = 3'b101;
        HSIZE_M     = {3'd2, 3'd1, 3'd0};
        HBURST_M    = {3'b001, 3'b000, 3'b011};
        HPROT_M     = {4'h4, 4'h2, 4'h1};
        HWDATA_M    = {32'hD000_0002, 32'hD000_0001, 32'hD000_0000};
        HREADY      = 1'b1;
        HRESP       = 1'b0;
        HRDATA      = '0;

        test_reset();
        test_park();
        test_handover();
        test_burst();
        test_rr_wrap();
        test_wait_error();
        test_lock();
        test_async_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
